// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : grf_wb_arbiter
//  Description : Owns the GRF write port. Shares it between W-stage
//                writeback (priority) and multiply/divide results, which are
//                buffered in a small FIFO. Tracks registers with MD results
//                still in flight and stalls decode on hazards against them or
//                when the MD FIFO has been starved for too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_wb_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_a3,
    input  logic [31:0] wb_wd,
    input  logic [31:0] wb_pc,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_a3,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_a3,
    input  logic [31:0] md_wd,
    input  logic [31:0] md_pc,
    input  logic [4:0]  d_a1,
    input  logic [4:0]  d_a2,
    input  logic [4:0]  d_a3,
    output logic        stall_d,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    localparam int unsigned c_ptr_w  = $clog2(DEPTH);
    localparam int unsigned c_cnt_w  = $clog2(DEPTH + 1);
    localparam int unsigned c_scnt_w = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [c_cnt_w-1:0]  c_depth      = c_cnt_w'(DEPTH);
    localparam logic [c_scnt_w-1:0] c_starve_max = c_scnt_w'(STARVE_MAX);

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } md_entry_t;

    md_entry_t             fifo_q [DEPTH];
    md_entry_t             fifo_d [DEPTH];
    logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0]    count_q, count_d;
    logic [31:0]           pending_q, pending_d;
    logic [c_scnt_w-1:0]   scnt_q, scnt_d;

    md_entry_t             w_head;
    logic                  w_grant_wb;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue_set;
    logic                  w_stall;

    // Grant, handshake and hazard decode for the current cycle
    always_comb begin
        w_head       = fifo_q[rd_ptr_q];
        w_fifo_empty = (count_q == '0);
        w_grant_wb   = wb_we && (wb_a3 != 5'd0);
        // W always wins; the FIFO head drains only when W leaves the port idle
        w_pop        = !reset && !w_grant_wb && !w_fifo_empty;
        md_ready     = !reset && (count_q < c_depth);
        w_push       = md_valid && md_ready;

        w_stall = !reset && (
                     ((d_a1 != 5'd0) && pending_q[d_a1]) ||
                     ((d_a2 != 5'd0) && pending_q[d_a2]) ||
                     ((d_a3 != 5'd0) && pending_q[d_a3]) ||
                     (md_issue && (count_q == c_depth)) ||
                     (scnt_q >= c_starve_max));
        stall_d     = w_stall;
        w_issue_set = md_issue && !w_stall && (md_issue_a3 != 5'd0);

        grf_we = 1'b0;
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        grf_pc = 32'd0;
        if (!reset) begin
            if (w_grant_wb) begin
                grf_we = 1'b1;
                grf_a3 = wb_a3;
                grf_wd = wb_wd;
                grf_pc = wb_pc;
            end else if (!w_fifo_empty) begin
                // A result aimed at r0 still consumes its slot but never writes
                grf_we = (w_head.a3 != 5'd0);
                grf_a3 = w_head.a3;
                grf_wd = w_head.wd;
                grf_pc = w_head.pc;
            end
        end
    end

    // Next-state for FIFO storage, pointers, scoreboard and starve counter
    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (w_push) begin
            fifo_d[wr_ptr_q] = '{a3: md_a3, wd: md_wd, pc: md_pc};
            wr_ptr_d         = wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase

        // Clear first so that a same-cycle set of the same register wins
        pending_d = pending_q;
        if (w_pop && (w_head.a3 != 5'd0)) begin
            pending_d[w_head.a3] = 1'b0;
        end
        if (w_issue_set) begin
            pending_d[md_issue_a3] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (w_fifo_empty || w_pop) begin
            scnt_d = '0;
        end else if (scnt_q < c_starve_max) begin
            scnt_d = scnt_q + c_scnt_w'(1);
        end else begin
            scnt_d = scnt_q;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            scnt_q    <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            scnt_q    <= scnt_d;
        end
    end

    // FIFO payload storage; contents are meaningless unless counted valid
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule
`default_nettype wire
